tinyalu_arbiter: RTL and testbench
==================================

TINYALU_ARBITER -- requirements
Module: tinyalu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one tinyalu, legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: done-watchdog limit, used only with the REQ-027 macro.
REQ-003 Port clk, input, 1: single clock; all logic is posedge clk.
REQ-004 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port req, input, NUM_REQ: per-requester request, held high until that requester's rsp_valid.
REQ-006 Port req_a, input, 8*NUM_REQ: operand A for requester i, in bits [8i+7:8i].
REQ-007 Port req_b, input, 8*NUM_REQ: operand B for requester i, packed the same as req_a.
REQ-008 Port req_op, input, 3*NUM_REQ: op_type for requester i, in bits [3i+2:3i].
REQ-009 Port rsp_valid, output, NUM_REQ: one-cycle completion pulse to the granted requester.
REQ-010 Port rsp_result, output, 16: result, valid while any rsp_valid bit is high.
REQ-011 Port rsp_err, output, 1: timeout error flag, qualified by rsp_valid.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port gnt_id, output, 3: index of the current or last winner.
REQ-014 Ports alu_a (output, 8), alu_b (output, 8), alu_op (output, 3), alu_start (output, 1), alu_reset_n (output, 1): tinyalu drive.
REQ-015 Ports alu_done (input, 1), alu_result (input, 16): tinyalu status.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: when any eligible req is high, select a winner round-robin, latch its A/B/op into registers, set gnt_id, go to ISSUE; otherwise stay in IDLE.
REQ-018 Round-robin: search begins at index ptr and wraps at NUM_REQ-1 to 0; ptr becomes winner+1 modulo NUM_REQ on each grant.
REQ-019 In the first IDLE cycle after RESP, the last winner is ineligible, so a late req deassert does not cause a double grant.
REQ-020 ISSUE: drive latched operands on alu_a/alu_b/alu_op, alu_start=1.
  - no_op: go to RESP next; result=0.
  - rst_op: alu_start=0, alu_reset_n=0 for exactly this one cycle, go to RESP; result=0.
  - add/and/xor/mul: go to WAIT.
REQ-021 WAIT: hold alu_start=1 and operands stable; on the first edge where alu_done=1, capture alu_result, drop alu_start, go to RESP.
REQ-022 RESP: rsp_valid[gnt_id]=1 for exactly one cycle, rsp_result=captured value, then go to IDLE.
REQ-023 Minimum turnaround SHALL be ISSUE+WAIT(done)+RESP; no op may issue while busy=1.
REQ-024 Simultaneous requests SHALL be served in round-robin order with no starvation; worst case wait is NUM_REQ-1 operations.
REQ-025 A req falling while not granted SHALL be ignored; req, operands and op changing after grant SHALL have no effect, because they are latched.

Reset
REQ-026 While reset_n=0, asynchronously:
  - state=IDLE, ptr=0, gnt_id=0;
  - rsp_valid=0, rsp_result=0, rsp_err=0;
  - alu_start=0, alu_a/alu_b=0, alu_op=no_op;
  - alu_reset_n=0.
  Reset mid-operation abandons the operation and issues no response; alu_reset_n SHALL be 1 from the first clk edge after reset_n rises.

Configuration
REQ-027 Macro TINYALU_ARB_TIMEOUT_EN.
  - Defined: a counter runs in WAIT; if alu_done is still 0 after TIMEOUT_CYCLES cycles, pulse alu_reset_n=0 for one cycle, drop alu_start, go to RESP with rsp_err=1 and rsp_result=16'hDEAD.
  - Undefined: no counter; WAIT is unbounded; rsp_err is tied 0.

Structure
REQ-028 op_type (no_op=3'b000, add_op=3'b001, and_op=3'b010, xor_op=3'b011, mul_op=3'b100, rst_op=3'b111) SHALL come from the shared tinyalu package, together with the arbiter state enum and the 16'hDEAD constant.
REQ-029 The round-robin selector SHALL be a separate sub-module, tinyalu_rr_picker: inputs req, mask and ptr; outputs grant_valid and grant_idx.

Verification
REQ-030 Single add: req[0], A=8'h12, B=8'h34 -> alu_start held until alu_done; rsp_valid[0] one cycle; rsp_result=16'h0046.
REQ-031 All four requesters issue mul 8'hFF*8'hFF in the same cycle -> grants in order 0,1,2,3; each rsp_result=16'hFE01; no double grant.
REQ-032 no_op on req[2] -> alu_start high for 1 cycle, no wait on alu_done; rsp_valid[2] follows; rsp_result=0.
REQ-033 rst_op on req[1] -> alu_reset_n low exactly 1 cycle and alu_start=0; rsp_valid[1] follows.
REQ-034 reset_n asserted during WAIT of a mul -> all outputs reset immediately; no rsp_valid; next req served starting from requester 0.
REQ-035 With TINYALU_ARB_TIMEOUT_EN defined and alu_done stuck 0 -> after 16 cycles: alu_reset_n pulse, rsp_valid with rsp_err=1, rsp_result=16'hDEAD.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// Shared tinyalu types: op codes, arbiter states, timeout result.
// Optional done-watchdog is enabled by TINYALU_ARB_TIMEOUT_EN.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  localparam logic [15:0] TIMEOUT_RESULT = 16'hDEAD;

  function automatic logic needs_done(input op_t op);
    return (op == add_op) || (op == and_op) ||
           (op == xor_op) || (op == mul_op);
  endfunction

endpackage

// File: rtl/tinyalu_rr_picker.sv
// Round-robin winner select: first eligible index at or after ptr.
// Eligible means requesting and not masked.
module tinyalu_rr_picker
  import tinyalu_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [2:0]         ptr,
  output logic               grant_valid,
  output logic [2:0]         grant_idx
);

  logic [NUM_REQ-1:0] elig;

  assign elig = req & ~mask;

  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!grant_valid && elig[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter sharing one tinyalu among NUM_REQ requesters.
// Define TINYALU_ARB_TIMEOUT_EN for the alu_done watchdog.
module tinyalu_arbiter
  import tinyalu_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  input  logic [3*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_result,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [2:0]             gnt_id,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [2:0]             alu_op,
  output logic                   alu_start,
  output logic                   alu_reset_n,
  input  logic                   alu_done,
  input  logic [15:0]            alu_result
);

  arb_state_t  state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  op_t         op_q, op_d;
  logic [15:0] res_q, res_d;
  logic        last_q, last_d;
  logic        arst_q, arst_d;
  logic        err_q;
  logic        wd_fire;

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] one_hot;
  logic               pick_valid;
  logic [2:0]         pick_idx;

  assign one_hot = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
  // Last winner sits out the first IDLE cycle after its response
  assign mask    = last_q ? one_hot : '0;

  tinyalu_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req         (req),
    .mask        (mask),
    .ptr         (ptr_q),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

`ifdef TINYALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == IDLE && pick_valid) begin
      err_d = 1'b0;
    end
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == WAIT && !alu_done) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LIMIT) begin
        err_d = 1'b1;
      end
    end
  end

  assign wd_fire = (state_q == WAIT) && !alu_done && (cnt_q == LIMIT);
`else
  assign err_q   = 1'b0;
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    last_d  = (state_q == RESP);
    arst_d  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          a_d     = req_a[8*int'(pick_idx) +: 8];
          b_d     = req_b[8*int'(pick_idx) +: 8];
          op_d    = op_t'(req_op[3*int'(pick_idx) +: 3]);
          gnt_d   = pick_idx;
          ptr_d   = (pick_idx == 3'(NUM_REQ - 1)) ?
                    3'd0 : pick_idx + 3'd1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (needs_done(op_q)) begin
          state_d = WAIT;
        end else begin
          res_d   = '0;
          state_d = RESP;
        end
      end
      WAIT: begin
        if (alu_done) begin
          res_d   = alu_result;
          state_d = RESP;
        end else if (wd_fire) begin
          res_d   = TIMEOUT_RESULT;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= no_op;
      res_q   <= '0;
      last_q  <= 1'b0;
      arst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      last_q  <= last_d;
      arst_q  <= arst_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign gnt_id     = gnt_q;
  assign rsp_valid  = (state_q == RESP) ? one_hot : '0;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign alu_start  = ((state_q == ISSUE) && (op_q != rst_op)) ||
                      (state_q == WAIT);
  // Low in reset, for a rst_op issue, and in a timed-out response
  assign alu_reset_n = arst_q &&
                       !((state_q == ISSUE) && (op_q == rst_op)) &&
                       !((state_q == RESP) && err_q);

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Self-checking bench for tinyalu_arbiter with a behavioural tinyalu.
// Timeout sequence is built only with TINYALU_ARB_TIMEOUT_EN.
module tb_tinyalu_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_a, req_b;
  logic [3*N-1:0] req_op;
  logic [N-1:0]   rsp_valid;
  logic [15:0]    rsp_result;
  logic           rsp_err, busy;
  logic [2:0]     gnt_id;
  logic [7:0]     alu_a, alu_b;
  logic [2:0]     alu_op;
  logic           alu_start, alu_reset_n;
  logic           alu_done = 1'b0;
  logic [15:0]    alu_result = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tinyalu_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_a(req_a),
    .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .gnt_id(gnt_id), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_start(alu_start),
    .alu_reset_n(alu_reset_n), .alu_done(alu_done),
    .alu_result(alu_result)
  );

  function automatic logic [15:0] ref_res(
    input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural tinyalu: done after a random 1..4 cycles of start
  bit alu_stuck = 1'b0;
  int alu_cnt = 0;
  int alu_lat = 2;
  always @(negedge clk) begin
    if (alu_start && !alu_stuck &&
        alu_op inside {3'b001, 3'b010, 3'b011, 3'b100}) begin
      if (alu_cnt == 0) alu_lat = $urandom_range(1, 4);
      alu_cnt++;
      if (alu_cnt >= alu_lat) begin
        alu_done   = 1'b1;
        alu_result = ref_res(alu_op, alu_a, alu_b);
      end
    end else begin
      alu_cnt  = 0;
      alu_done = 1'b0;
    end
  end

  task automatic set_req(input int id, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    req_a[8*id +: 8]  = a;
    req_b[8*id +: 8]  = b;
    req_op[3*id +: 3] = op;
    req[id]           = 1'b1;
  endtask

  typedef struct {
    int          id;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  task automatic run_single(input vec_t v);
    int starts = 0;
    int rlow = 0;
    int cyc = 0;
    bit got = 0;
    string nm;
    nm = $sformatf("op%0d_req%0d", v.op, v.id);
    set_req(v.id, v.op, v.a, v.b);
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && busy) req_a[8*v.id +: 8] = ~v.a;
      if (alu_start) starts++;
      if (!alu_reset_n) begin
        rlow++;
        check({nm, "_start_in_rst"}, 32'(alu_start), 0);
      end
      if (|rsp_valid) begin
        got = 1;
        req[v.id] = 1'b0;
        check({nm, "_valid"}, 32'(rsp_valid), 32'(1 << v.id));
        check({nm, "_result"}, 32'(rsp_result), 32'(v.exp));
        check({nm, "_err"}, 32'(rsp_err), 0);
      end
    end
    if (!got) check({nm, "_no_response"}, 0, 1);
    if (v.op == 3'b000) check({nm, "_start_cycles"}, starts, 1);
    if (v.op == 3'b111) begin
      check({nm, "_rstn_low_cycles"}, rlow, 1);
      check({nm, "_start_cycles"}, starts, 0);
    end
    if (v.op inside {3'b001, 3'b010, 3'b011, 3'b100}) begin
      check({nm, "_start_ge2"}, 32'(starts >= 2), 1);
      check({nm, "_no_rst"}, rlow, 0);
    end
    @(negedge clk);
    check({nm, "_one_cycle"}, 32'(rsp_valid), 0);
  endtask

  vec_t tbl[7];
  int   model_ptr;
  logic [2:0] rop[N];
  logic [7:0] ra[N], rb[N];

  initial begin
    reset_n = 1'b0;
    req = '0; req_a = '0; req_b = '0; req_op = '0;
    tbl[0] = '{0, 3'b001, 8'h12, 8'h34, 16'h0046};
    tbl[1] = '{2, 3'b000, 8'h55, 8'h66, 16'h0000};
    tbl[2] = '{1, 3'b111, 8'hAA, 8'h01, 16'h0000};
    tbl[3] = '{3, 3'b010, 8'hF0, 8'h3C, 16'h0030};
    tbl[4] = '{1, 3'b011, 8'hF0, 8'h3C, 16'h00CC};
    tbl[5] = '{0, 3'b100, 8'h10, 8'h10, 16'h0100};
    tbl[6] = '{2, 3'b001, 8'hFF, 8'hFF, 16'h01FE};

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_result", 32'(rsp_result), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_gnt_id", 32'(gnt_id), 0);
    check("rst_alu_start", 32'(alu_start), 0);
    check("rst_alu_ab", 32'({alu_a, alu_b}), 0);
    check("rst_alu_op", 32'(alu_op), 0);
    check("rst_alu_reset_n", 32'(alu_reset_n), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("alu_reset_n_released", 32'(alu_reset_n), 1);

    for (int i = 0; i < 7; i++) run_single(tbl[i]);

    // Reset abandons a mul stuck in WAIT
    alu_stuck = 1'b1;
    set_req(3, 3'b100, 8'h07, 8'h09);
    repeat (4) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 1);
    check("midrst_start_before", 32'(alu_start), 1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_start", 32'(alu_start), 0);
    check("midrst_alu_reset_n", 32'(alu_reset_n), 0);
    check("midrst_gnt", 32'(gnt_id), 0);
    check("midrst_valid", 32'(rsp_valid), 0);
    req = '0;
    alu_stuck = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_no_rsp", 32'(rsp_valid), 0);

    // Four simultaneous muls after reset: served 0,1,2,3
    begin
      int served = 0;
      int cyc = 0;
      for (int i = 0; i < N; i++) set_req(i, 3'b100, 8'hFF, 8'hFF);
      while (served < N && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (|rsp_valid) begin
          check($sformatf("rr4_order%0d", served),
                32'(rsp_valid), 32'(1 << served));
          check($sformatf("rr4_result%0d", served),
                32'(rsp_result), 32'h0000FE01);
          req = req & ~rsp_valid;
          served++;
        end
      end
      check("rr4_served", served, N);
      repeat (3) @(negedge clk);
      check("rr4_no_extra", 32'(rsp_valid | {N{busy}}), 0);
    end

    // Random traffic against an abstract round-robin scoreboard
    model_ptr = 0;
    begin
      logic [N-1:0] seen;
      bit   prev_busy = 0;
      int   exp_w = -1;
      logic [15:0] exp_r = '0;
      int   grants = 0;
      int   resps = 0;
      seen = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        int drop;
        @(negedge clk);
        drop = -1;
        if (busy && !prev_busy) begin
          exp_w = -1;
          for (int k = 0; k < N; k++) begin
            int j;
            j = (model_ptr + k) % N;
            if (exp_w < 0 && seen[j]) exp_w = j;
          end
          check("rand_grant_id", 32'(gnt_id), 32'(exp_w));
          if (exp_w >= 0) begin
            exp_r = ref_res(rop[exp_w], ra[exp_w], rb[exp_w]);
            model_ptr = (exp_w + 1) % N;
            req_a[8*exp_w +: 8] = 8'($urandom);
            req_b[8*exp_w +: 8] = 8'($urandom);
            req_op[3*exp_w +: 3] = 3'b100;
          end
          grants++;
        end
        if (|rsp_valid) begin
          check("rand_rsp_valid", 32'(rsp_valid),
                exp_w >= 0 ? 32'(1 << exp_w) : 0);
          check("rand_rsp_result", 32'(rsp_result), 32'(exp_r));
          check("rand_rsp_err", 32'(rsp_err), 0);
          if (exp_w >= 0) begin
            req[exp_w] = 1'b0;
            drop = exp_w;
          end
          resps++;
        end
        for (int i = 0; i < N; i++) begin
          if (!req[i] && i != drop && $urandom_range(0, 3) == 0) begin
            logic [2:0] ops[6];
            ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
            rop[i] = ops[$urandom_range(0, 5)];
            ra[i]  = 8'($urandom);
            rb[i]  = 8'($urandom);
            set_req(i, rop[i], ra[i], rb[i]);
          end
        end
        seen = req;
        prev_busy = busy;
      end
      check("rand_progress", 32'(resps > 20), 1);
      check("rand_grants_vs_resps", 32'(grants - resps <= 1), 1);
    end

    // Drain outstanding requests before the final sequence
    begin
      int cyc = 0;
      while ((|req || busy) && cyc < 400) begin
        @(negedge clk);
        cyc++;
        if (|rsp_valid) req = req & ~rsp_valid;
      end
      check("drain_done", 32'(|req || busy), 0);
      repeat (2) @(negedge clk);
    end

`ifdef TINYALU_ARB_TIMEOUT_EN
    begin
      int starts = 0;
      int rlow = 0;
      int cyc = 0;
      bit got = 0;
      alu_stuck = 1'b1;
      set_req(0, 3'b001, 8'h01, 8'h02);
      while (!got && cyc < 100) begin
        @(negedge clk);
        cyc++;
        if (alu_start) starts++;
        if (!alu_reset_n) rlow++;
        if (|rsp_valid) begin
          got = 1;
          req[0] = 1'b0;
          check("to_valid", 32'(rsp_valid), 1);
          check("to_err", 32'(rsp_err), 1);
          check("to_result", 32'(rsp_result), 32'h0000DEAD);
          check("to_rstn_in_rsp", 32'(alu_reset_n), 0);
          check("to_start_in_rsp", 32'(alu_start), 0);
        end
      end
      check("to_got_rsp", 32'(got), 1);
      check("to_start_cycles", starts, 17);
      check("to_rstn_low_cycles", rlow, 1);
      alu_stuck = 1'b0;
      @(negedge clk);
      check("to_rstn_back", 32'(alu_reset_n), 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
